// File: rtl/time_set_sequencer.sv
// Stopwatch set-time sequencer: edits a BCD MM:SS value with a blinking digit cursor and
// strobes load_time for one cycle when edit mode ends. All outputs registered, 1-cycle latency.
module time_set_sequencer #(
   parameter int BLINK_HALF = 50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        set,
   input  logic        up,
   input  logic        down,
   input  logic        left,
   input  logic        right,
   input  logic [15:0] cur_time,
   output logic [15:0] time_out,
   output logic        load_time,
   output logic        editing,
   output logic [1:0]  cursor,
   output logic [3:0]  blank_mask
);

   localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);

   typedef enum logic [1:0] {IDLE, EDIT, LOAD} state_t;

   state_t        state, state_n;
   logic          set_d;
   logic          rise_pend, rise_pend_n;
   logic [15:0]   digs, digs_n;
   logic [1:0]    cursor_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          phase, phase_n;
   logic          load_n, edit_n;
   logic [3:0]    blank_n;
   logic [3:0]    sel, sel_n, dmax;

   assign time_out = digs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         set_d      <= 1'b0;
         rise_pend  <= 1'b0;
         digs       <= '0;
         cursor     <= '0;
         cnt        <= '0;
         phase      <= 1'b0;
         load_time  <= 1'b0;
         editing    <= 1'b0;
         blank_mask <= '0;
      end else begin
         state      <= state_n;
         set_d      <= set;
         rise_pend  <= rise_pend_n;
         digs       <= digs_n;
         cursor     <= cursor_n;
         cnt        <= cnt_n;
         phase      <= phase_n;
         load_time  <= load_n;
         editing    <= edit_n;
         blank_mask <= blank_n;
      end
   end

   always_comb begin
      state_n     = state;
      rise_pend_n = 1'b0;
      digs_n      = digs;
      cursor_n    = cursor;
      cnt_n       = cnt;
      phase_n     = phase;
      load_n      = 1'b0;
      edit_n      = 1'b0;
      blank_n     = 4'b0000;
      sel         = digs[{cursor, 2'b00} +: 4];
      dmax        = (cursor == 2'd1) ? 4'd5 : 4'd9;
      sel_n       = sel;

      case (state)
         IDLE: begin
            // A rise seen during LOAD is remembered so it still opens an edit here
            if (set && (!set_d || rise_pend)) begin
               state_n  = EDIT;
               digs_n   = cur_time;
               cursor_n = 2'd0;
               cnt_n    = '0;
               phase_n  = 1'b0;
               edit_n   = 1'b1;
            end
         end
         EDIT: begin
            if (!set) begin
               state_n = LOAD;
               load_n  = 1'b1;
            end else begin
               edit_n = 1'b1;
               // Out-of-range snapshot digits fall into the wrap branches
               if (up && !down)
                  sel_n = (sel >= dmax) ? 4'd0 : sel + 4'd1;
               else if (down && !up)
                  sel_n = (sel == 4'd0 || sel > dmax) ? dmax : sel - 4'd1;
               digs_n[{cursor, 2'b00} +: 4] = sel_n;

               if (left ^ right) begin
                  cursor_n = left ? cursor + 2'd1 : cursor - 2'd1;
                  cnt_n    = '0;
                  phase_n  = 1'b0;
               end else if (cnt == CNT_LAST) begin
                  cnt_n   = '0;
                  phase_n = ~phase;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
               blank_n = phase_n ? (4'b0001 << cursor_n) : 4'b0000;
            end
         end
         LOAD: begin
            state_n     = IDLE;
            rise_pend_n = set && !set_d;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_time_set_sequencer.sv
// Vector-table bench for time_set_sequencer with a queue scoreboard and a mid-edit reset sequence.
module tb_time_set_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        set, up, down, left, right;
   logic [15:0] cur_time;
   logic [15:0] time_out;
   logic        load_time, editing;
   logic [1:0]  cursor;
   logic [3:0]  blank_mask;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        s, u, d, l, r;
      logic [15:0] cur;
      logic [15:0] t;
      logic [1:0]  c;
      logic        ed, ld;
      logic [3:0]  bm;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   time_set_sequencer #(.BLINK_HALF(4)) dut (
      .clk(clk), .rst(rst), .set(set), .up(up), .down(down), .left(left), .right(right),
      .cur_time(cur_time), .time_out(time_out), .load_time(load_time), .editing(editing),
      .cursor(cursor), .blank_mask(blank_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic s, u, d, l, r, input logic [15:0] cur, input logic [15:0] t,
                      input logic [1:0] c, input logic ed, ld, input logic [3:0] bm);
      vec_t v;
      v.s = s; v.u = u; v.d = d; v.l = l; v.r = r; v.cur = cur;
      v.t = t; v.c = c; v.ed = ed; v.ld = ld; v.bm = bm;
      tbl.push_back(v);
   endtask

   task automatic step(input vec_t v, input string tag);
      vec_t e;
      @(negedge clk);
      set = v.s; up = v.u; down = v.d; left = v.l; right = v.r; cur_time = v.cur;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, " time_out"}, time_out, e.t);
         chk({tag, " cursor"}, 16'(cursor), 16'(e.c));
         chk({tag, " editing"}, 16'(editing), 16'(e.ed));
         chk({tag, " load_time"}, 16'(load_time), 16'(e.ld));
         chk({tag, " blank_mask"}, 16'(blank_mask), 16'(e.bm));
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " time_out"}, time_out, 16'h0000);
      chk({tag, " cursor"}, 16'(cursor), 16'h0);
      chk({tag, " editing"}, 16'(editing), 16'h0);
      chk({tag, " load_time"}, 16'(load_time), 16'h0);
      chk({tag, " blank_mask"}, 16'(blank_mask), 16'h0);
   endtask

   initial begin
      vec_t v;
      rst = 1'b1; set = 0; up = 0; down = 0; left = 0; right = 0; cur_time = 16'h1234;

      //   s u d l r  cur       time_out   c   ed ld bm
      add(1,0,0,0,0, 16'h1234, 16'h1234, 0, 1, 0, 4'h0);  // enter edit
      for (int i = 0; i < 3; i++) add(1,0,0,0,0, 16'h1234, 16'h1234, 0, 1, 0, 4'h0);
      for (int i = 0; i < 4; i++) add(1,0,0,0,0, 16'h1234, 16'h1234, 0, 1, 0, 4'h1);
      add(1,0,0,0,0, 16'h1234, 16'h1234, 0, 1, 0, 4'h0);
      add(1,0,0,1,0, 16'h1234, 16'h1234, 1, 1, 0, 4'h0);  // left restarts blink
      for (int i = 0; i < 3; i++) add(1,0,0,0,0, 16'h1234, 16'h1234, 1, 1, 0, 4'h0);
      add(1,0,0,0,0, 16'h1234, 16'h1234, 1, 1, 0, 4'h2);
      add(1,1,0,0,0, 16'h1234, 16'h1244, 1, 1, 0, 4'h2);
      add(1,1,0,0,0, 16'h1234, 16'h1254, 1, 1, 0, 4'h2);
      add(1,1,0,0,0, 16'h1234, 16'h1204, 1, 1, 0, 4'h2);  // s_tens 5 -> 0
      add(1,0,1,0,0, 16'h1234, 16'h1254, 1, 1, 0, 4'h0);  // s_tens 0 -> 5
      add(1,1,1,0,0, 16'h1234, 16'h1254, 1, 1, 0, 4'h0);  // up & down
      add(1,0,0,1,1, 16'h1234, 16'h1254, 1, 1, 0, 4'h0);  // left & right
      add(1,0,0,0,1, 16'h1234, 16'h1254, 0, 1, 0, 4'h0);
      add(1,0,0,0,1, 16'h1234, 16'h1254, 3, 1, 0, 4'h0);  // 0 -> 3
      add(1,0,1,0,0, 16'h1234, 16'h0254, 3, 1, 0, 4'h0);
      add(1,0,1,0,0, 16'h1234, 16'h9254, 3, 1, 0, 4'h0);  // m_tens 0 -> 9
      add(1,0,0,1,0, 16'h1234, 16'h9254, 0, 1, 0, 4'h0);  // 3 -> 0
      add(1,1,0,0,0, 16'h1234, 16'h9255, 0, 1, 0, 4'h0);
      add(1,1,0,0,0, 16'h1234, 16'h9256, 0, 1, 0, 4'h0);
      add(1,1,0,0,0, 16'h1234, 16'h9257, 0, 1, 0, 4'h0);
      add(1,1,0,0,0, 16'h1234, 16'h9258, 0, 1, 0, 4'h1);
      add(1,1,0,0,0, 16'h1234, 16'h9259, 0, 1, 0, 4'h1);
      add(1,1,0,0,0, 16'h1234, 16'h9250, 0, 1, 0, 4'h1);  // s_units 9 -> 0
      add(1,0,1,0,0, 16'h1234, 16'h9259, 0, 1, 0, 4'h1);
      add(1,0,0,1,0, 16'h1234, 16'h9259, 1, 1, 0, 4'h0);  // move while blanked
      add(1,0,1,0,0, 16'h1234, 16'h9249, 1, 1, 0, 4'h0);
      add(1,1,0,1,0, 16'h1234, 16'h9259, 2, 1, 0, 4'h0);  // edit pre-move cursor
      add(1,0,0,1,0, 16'h1234, 16'h9259, 3, 1, 0, 4'h0);
      add(1,1,0,0,0, 16'h1234, 16'h0259, 3, 1, 0, 4'h0);
      add(1,0,0,0,1, 16'h1234, 16'h0259, 2, 1, 0, 4'h0);
      add(1,0,1,0,0, 16'h1234, 16'h0159, 2, 1, 0, 4'h0);
      add(1,0,1,0,0, 16'h1234, 16'h0059, 2, 1, 0, 4'h0);
      add(1,0,1,0,0, 16'h1234, 16'h0959, 2, 1, 0, 4'h0);
      add(0,1,0,0,0, 16'h1234, 16'h0959, 2, 0, 1, 4'h0);  // load strobe, pulse ignored
      add(0,1,0,0,0, 16'h1234, 16'h0959, 2, 0, 0, 4'h0);
      add(0,1,0,0,0, 16'h1234, 16'h0959, 2, 0, 0, 4'h0);
      add(1,0,0,0,0, 16'h0070, 16'h0070, 0, 1, 0, 4'h0);  // out-of-range s_tens
      add(1,0,0,1,0, 16'h0070, 16'h0070, 1, 1, 0, 4'h0);
      add(1,1,0,0,0, 16'h0070, 16'h0000, 1, 1, 0, 4'h0);
      add(1,0,1,0,0, 16'h0070, 16'h0050, 1, 1, 0, 4'h0);

      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

      // Async reset in the middle of an edit
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      set = 1'b0;
      cur_time = 16'h4321;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_no_load", 16'(load_time), 16'h0);
      end
      @(negedge clk);
      rst = 1'b0;

      v = tbl[0];
      v.s = 0; v.cur = 16'h4321; v.t = 16'h0000; v.ed = 0;
      step(v, "post_rst_idle");
      v.s = 1; v.t = 16'h4321; v.ed = 1;
      step(v, "resnapshot");
      v.s = 0; v.t = 16'h4321; v.ed = 0; v.ld = 1;
      step(v, "reload");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
